// File: rtl/systolic_sequencer_pkg.sv
// systolic_sequencer_pkg: shared state type and timing constants for the tile sequencer
package systolic_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, WAIT_WT, LOAD_WT, STREAM, DRAIN, DONE} seq_state_e;
    localparam int N_DEF = 16;
    localparam int UB_RD_LAT_DEF = 1;
    function automatic int pipe_lat(input int ub_rd_lat, input int n);
        return ub_rd_lat + 2 * n - 1;
    endfunction
endpackage

// File: rtl/systolic_sequencer_valid_delay_line.sv
// valid_delay_line: DEPTH-stage valid shift register with synchronous clear
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic clr,
    input  logic valid_in,
    output logic valid_out,
    output logic any_valid
);
    logic [DEPTH-1:0] q;
    // shift tokens toward the output; clear drops everything still in flight
    always_ff @(posedge clk) begin
        if (clr) q <= '0;
        else begin
            q[0] <= valid_in;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
        end
    end
    assign valid_out = q[DEPTH-1];
    assign any_valid = |q;
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: weight load, activation streaming and accumulator write sequencing for one tile
module systolic_sequencer
    import systolic_sequencer_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int ADDR_W    = 8,
    parameter int ROWS_W    = 8,
    parameter int UB_RD_LAT = UB_RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sys_start,
    input  logic [ROWS_W-1:0] sys_rows,
    input  logic [ADDR_W-1:0] ub_base,
    input  logic [ADDR_W-1:0] acc_base,
    input  logic              acc_buf_sel,
    input  logic              wt_ready,
    output logic              sys_busy,
    output logic              sys_done,
    output logic              wt_load,
    output logic              ub_rd_en,
    output logic [ADDR_W-1:0] ub_rd_addr,
    output logic              array_valid,
    output logic              acc_wr_en,
    output logic [ADDR_W:0]   acc_wr_addr
);
    localparam int PIPE_LAT = pipe_lat(UB_RD_LAT, N);
    localparam int LD_W = $clog2(N) + 1;
    seq_state_e state, state_nxt;
    logic [LD_W-1:0] ld_cnt;
    logic [ROWS_W-1:0] rd_left, wr_left;
    logic [ADDR_W-1:0] wr_ptr;
    logic sel_q, acc_pre, arr_any, acc_any, drain_exit;
    // acc_wr_en is a register behind a PIPE_LAT-1 line, so acc_pre previews the next write;
    // leave DRAIN while the final write is being registered so DONE lines up with it
    assign drain_exit = (acc_pre && wr_left == ROWS_W'(1)) || !(arr_any || acc_any);
    assign acc_wr_addr = {sel_q, wr_ptr};
    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = sys_start ? (sys_rows == '0 ? DONE : WAIT_WT) : IDLE;
            WAIT_WT: state_nxt = wt_ready ? LOAD_WT : WAIT_WT;
            LOAD_WT: state_nxt = ld_cnt == LD_W'(N - 1) ? STREAM : LOAD_WT;
            STREAM:  state_nxt = rd_left == ROWS_W'(1) ? DRAIN : STREAM;
            DRAIN:   state_nxt = drain_exit ? DONE : DRAIN;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // state register with strobes registered in step with the state; done trails DONE by a cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sys_busy  <= 1'b0;
            wt_load   <= 1'b0;
            ub_rd_en  <= 1'b0;
            sys_done  <= 1'b0;
            acc_wr_en <= 1'b0;
        end else begin
            state     <= state_nxt;
            sys_busy  <= state_nxt != IDLE;
            wt_load   <= state_nxt == LOAD_WT;
            ub_rd_en  <= state_nxt == STREAM;
            sys_done  <= state == DONE;
            acc_wr_en <= acc_pre;
        end
    end
    // operand latch at start, then load/read/write counters and address pointers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ld_cnt     <= '0;
            rd_left    <= '0;
            wr_left    <= '0;
            ub_rd_addr <= '0;
            wr_ptr     <= '0;
            sel_q      <= 1'b0;
        end else begin
            ld_cnt <= state == LOAD_WT ? ld_cnt + 1'b1 : '0;
            if (state == IDLE && sys_start) begin
                rd_left    <= sys_rows;
                wr_left    <= sys_rows;
                ub_rd_addr <= ub_base;
                wr_ptr     <= acc_base;
                sel_q      <= acc_buf_sel;
            end else begin
                if (state == STREAM) begin
                    rd_left    <= rd_left - 1'b1;
                    ub_rd_addr <= ub_rd_addr + 1'b1;
                end
                if (acc_pre) wr_left <= wr_left - 1'b1;
                if (acc_wr_en) wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end
    valid_delay_line #(.DEPTH(UB_RD_LAT)) u_arr_line (
        .clk(clk), .clr(!rst_n), .valid_in(ub_rd_en), .valid_out(array_valid), .any_valid(arr_any)
    );
    valid_delay_line #(.DEPTH(PIPE_LAT - 1)) u_acc_line (
        .clk(clk), .clr(!rst_n), .valid_in(ub_rd_en), .valid_out(acc_pre), .any_valid(acc_any)
    );
endmodule

// File: tb/tb_systolic_sequencer.sv
// tb_systolic_sequencer: timeline-model checking of the systolic tile sequencer
module tb_systolic_sequencer;
    localparam int N = 4;
    localparam int UB_RD_LAT = 1;
    localparam int PIPE = UB_RD_LAT + 2 * N - 1;
    localparam int MAXC = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sys_start = 1'b0;
    logic [7:0] sys_rows = '0, ub_base = '0, acc_base = '0;
    logic acc_buf_sel = 1'b0, wt_ready = 1'b1;
    logic sys_busy, sys_done, wt_load, ub_rd_en, array_valid, acc_wr_en;
    logic [7:0] ub_rd_addr;
    logic [8:0] acc_wr_addr;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int n_done = 0;

    bit e_busy[MAXC], e_done[MAXC], e_wt[MAXC], e_rd[MAXC], e_arr[MAXC], e_wr[MAXC];
    logic [7:0] e_rd_addr[MAXC];
    logic [8:0] e_wr_addr[MAXC];

    systolic_sequencer #(.N(N), .ADDR_W(8), .ROWS_W(8), .UB_RD_LAT(UB_RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .sys_start(sys_start), .sys_rows(sys_rows),
        .ub_base(ub_base), .acc_base(acc_base), .acc_buf_sel(acc_buf_sel), .wt_ready(wt_ready),
        .sys_busy(sys_busy), .sys_done(sys_done), .wt_load(wt_load), .ub_rd_en(ub_rd_en),
        .ub_rd_addr(ub_rd_addr), .array_valid(array_valid), .acc_wr_en(acc_wr_en),
        .acc_wr_addr(acc_wr_addr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // expected timeline of one tile from its start cycle, row count and first wt_ready-high cycle
    task automatic plan_tile(input int t0, input int r, input int rdy, input logic [7:0] ub,
                             input logic [7:0] ab, input logic sel);
        int s, last;
        if (r == 0) begin
            e_busy[t0+1] = 1'b1;
            e_done[t0+2] = 1'b1;
            return;
        end
        s = rdy + 1 + N;
        last = s + r - 1 + PIPE;
        for (int c = t0 + 1; c <= last; c++) e_busy[c] = 1'b1;
        for (int c = rdy + 1; c < s; c++) e_wt[c] = 1'b1;
        for (int k = 0; k < r; k++) begin
            e_rd[s+k] = 1'b1;
            e_rd_addr[s+k] = 8'(ub + k);
            e_arr[s+k+UB_RD_LAT] = 1'b1;
            e_wr[s+k+PIPE] = 1'b1;
            e_wr_addr[s+k+PIPE] = {sel, 8'(ab + k)};
        end
        e_done[last+1] = 1'b1;
    endtask

    task automatic abort_from(input int c0);
        for (int c = c0; c < MAXC; c++) begin
            e_busy[c] = 0; e_done[c] = 0; e_wt[c] = 0; e_rd[c] = 0; e_arr[c] = 0; e_wr[c] = 0;
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic start_tile(input int r, input logic [7:0] ub, input logic [7:0] ab,
                              input logic sel, input int rdy_off, output int t0);
        @(negedge clk);
        t0 = cyc;
        sys_rows = 8'(r); ub_base = ub; acc_base = ab; acc_buf_sel = sel; sys_start = 1'b1;
        plan_tile(t0, r, t0 + rdy_off, ub, ab, sel);
        @(negedge clk);
        sys_start = 1'b0;
    endtask

    // compare every output against the model each cycle
    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            chk("sys_busy", sys_busy, e_busy[cyc]);
            chk("sys_done", sys_done, e_done[cyc]);
            chk("wt_load", wt_load, e_wt[cyc]);
            chk("ub_rd_en", ub_rd_en, e_rd[cyc]);
            chk("array_valid", array_valid, e_arr[cyc]);
            chk("acc_wr_en", acc_wr_en, e_wr[cyc]);
            if (e_rd[cyc]) chk("ub_rd_addr", ub_rd_addr, e_rd_addr[cyc]);
            if (e_wr[cyc]) chk("acc_wr_addr", acc_wr_addr, e_wr_addr[cyc]);
        end
        if (sys_done === 1'b1) n_done++;
    end

    initial begin
        int t0, d0;
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(6);
        // basic tile
        start_tile(3, 8'h10, 8'h20, 1'b1, 1, t0);
        wait_cyc(t0 + 2);  chk("s1_wt_first", wt_load, 1);
        wait_cyc(t0 + 6);  chk("s1_rd0", ub_rd_addr, 8'h10);
        wait_cyc(t0 + 14); chk("s1_wr0", {acc_wr_en, acc_wr_addr}, 10'h320);
        wait_cyc(t0 + 16); chk("s1_wr2", acc_wr_addr, 9'h122); chk("s1_no_early_done", sys_done, 0);
        wait_cyc(t0 + 17); chk("s1_done", sys_done, 1);
        wait_cyc(t0 + 20);
        // weight stall for five cycles
        wt_ready = 1'b0;
        start_tile(2, 8'h00, 8'h10, 1'b0, 6, t0);
        wait_cyc(t0 + 5);  chk("s2_busy_stall", {sys_busy, wt_load}, 2'b10);
        wait_cyc(t0 + 6);  wt_ready = 1'b1;
        wait_cyc(t0 + 7);  chk("s2_wt_first", wt_load, 1);
        wait_cyc(t0 + 21); chk("s2_done", sys_done, 1);
        wait_cyc(t0 + 24);
        // address wrap
        start_tile(3, 8'hFE, 8'hFF, 1'b0, 1, t0);
        wait_cyc(t0 + 8);  chk("s3_rd_wrap", ub_rd_addr, 8'h00);
        wait_cyc(t0 + 15); chk("s3_wr_wrap", acc_wr_addr, 9'h000);
        wait_cyc(t0 + 16); chk("s3_wr_last", acc_wr_addr, 9'h001);
        wait_cyc(t0 + 20);
        // zero rows
        start_tile(0, 8'h33, 8'h44, 1'b1, 1, t0);
        wait_cyc(t0 + 1);  chk("s4_busy", {sys_busy, sys_done}, 2'b10);
        wait_cyc(t0 + 2);  chk("s4_done", {sys_busy, sys_done}, 2'b01);
        wait_cyc(t0 + 5);
        // start while busy is ignored
        start_tile(3, 8'h30, 8'h40, 1'b0, 1, t0);
        d0 = n_done;
        wait_cyc(t0 + 7);
        sys_rows = 8'd5; ub_base = 8'h80; acc_base = 8'h90; acc_buf_sel = 1'b1; sys_start = 1'b1;
        @(negedge clk);
        sys_start = 1'b0;
        wait_cyc(t0 + 16); chk("s5_wr_addr", acc_wr_addr, 9'h042);
        wait_cyc(t0 + 24); chk("s5_one_done", n_done - d0, 1);
        // reset mid-DRAIN aborts the tile
        start_tile(2, 8'h50, 8'h60, 1'b1, 1, t0);
        wait_cyc(t0 + 10);
        rst_n = 1'b0;
        abort_from(t0 + 11);
        d0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        chk("s6_rst_outs", {sys_busy, acc_wr_en, array_valid, ub_rd_en}, 4'h0);
        wait_cyc(t0 + 24); chk("s6_no_done", n_done - d0, 0);
        // fresh tile after reset behaves like the basic tile
        start_tile(3, 8'h10, 8'h20, 1'b1, 1, t0);
        wait_cyc(t0 + 14); chk("s6_wr0", acc_wr_addr, 9'h120);
        wait_cyc(t0 + 17); chk("s6_done", sys_done, 1);
        wait_cyc(t0 + 22);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
